// File: rtl/ddr3_init_ctrl.sv
// DDR3 initialisation sequencer: power-up delay, init_start pulse, done/timeout
// supervision with bounded retries, and re-initialisation on request.
module ddr3_init_ctrl #(
    parameter int unsigned DLY_CYCLES     = 60,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned RETRY_W        = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               init_done_i,
    input  logic               reinit_req_i,
    output logic               init_start_o,
    output logic               init_ok_o,
    output logic               init_fail_o,
    output logic               busy_o,
    output logic [RETRY_W-1:0] retry_cnt_o
);

    localparam logic [CNT_W-1:0]   DlyLast  = CNT_W'(DLY_CYCLES - 1);
    localparam logic [CNT_W-1:0]   ToLast   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] MaxRetry = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        StIdle,
        StPwrDly,
        StStart,
        StWaitDone,
        StDone,
        StFail
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               init_start_q, init_ok_q, init_fail_q, busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        case (state_q)
            StIdle: begin
                state_d = StPwrDly;
                cnt_d   = '0;
            end
            StPwrDly: begin
                if (cnt_q == DlyLast) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStart: begin
                state_d = StWaitDone;
                cnt_d   = '0;
            end
            StWaitDone: begin
                // init_done in the expiry clock takes priority over the timeout
                if (init_done_i) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else if (cnt_q == ToLast) begin
                    cnt_d = '0;
                    if (retry_q < MaxRetry) begin
                        retry_d = retry_q + 1'b1;
                        state_d = StPwrDly;
                    end else begin
                        state_d = StFail;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone, StFail: begin
                if (reinit_req_i) begin
                    state_d = StPwrDly;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                retry_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    // Status flags are registered copies of the current state, so no input reaches an output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            init_start_q <= 1'b0;
            init_ok_q    <= 1'b0;
            init_fail_q  <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            init_start_q <= (state_q == StStart);
            init_ok_q    <= (state_q == StDone);
            init_fail_q  <= (state_q == StFail);
            busy_q       <= (state_q != StDone) && (state_q != StFail);
        end
    end

    assign init_start_o = init_start_q;
    assign init_ok_o    = init_ok_q;
    assign init_fail_o  = init_fail_q;
    assign busy_o       = busy_q;
    assign retry_cnt_o  = retry_q;

endmodule

// File: tb/tb_ddr3_init_ctrl.sv
// Directed bench for ddr3_init_ctrl: vector table for the main flow plus
// hand-written sequences for retry/fail, held init_done and mid-sequence reset.
module tb_ddr3_init_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       init_done_i = 1'b0;
    logic       reinit_req_i = 1'b0;
    logic       init_start_o, init_ok_o, init_fail_o, busy_o;
    logic [3:0] retry_cnt_o;

    int checks = 0;
    int errors = 0;

    ddr3_init_ctrl #(
        .DLY_CYCLES    (60),
        .TIMEOUT_CYCLES(100),
        .MAX_RETRY     (2),
        .CNT_W         (16),
        .RETRY_W       (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .init_done_i (init_done_i),
        .reinit_req_i(reinit_req_i),
        .init_start_o(init_start_o),
        .init_ok_o   (init_ok_o),
        .init_fail_o (init_fail_o),
        .busy_o      (busy_o),
        .retry_cnt_o (retry_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        int unsigned cycles;
        logic        rst;
        logic        done;
        logic        reinit;
        logic        start;
        logic        ok;
        logic        fail;
        logic        busy;
        logic [3:0]  retry;
    } vec_t;

    vec_t vecs[18];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic st, input logic ok, input logic fl,
                            input logic bz, input logic [3:0] rt);
        chk({name, ".start"}, 32'(init_start_o), 32'(st));
        chk({name, ".ok"}, 32'(init_ok_o), 32'(ok));
        chk({name, ".fail"}, 32'(init_fail_o), 32'(fl));
        chk({name, ".busy"}, 32'(busy_o), 32'(bz));
        chk({name, ".retry"}, 32'(retry_cnt_o), 32'(rt));
    endtask

    initial begin
        int pulses[$];
        int first_start;
        int first_ok;
        int n_start;

        // Edge counts are relative to the last reset edge or the edge that samples reinit_req.
        //          name          cyc  rst done rein start ok fail busy retry
        vecs[0]  = '{"reset",       3, 1, 1, 1, 0, 0, 0, 1, 0};
        vecs[1]  = '{"pwr_dly",    61, 0, 0, 0, 0, 0, 0, 1, 0};
        vecs[2]  = '{"start62",     1, 0, 0, 0, 1, 0, 0, 1, 0};
        vecs[3]  = '{"start_end",   1, 0, 0, 0, 0, 0, 0, 1, 0};
        vecs[4]  = '{"wait",        3, 0, 0, 0, 0, 0, 0, 1, 0};
        vecs[5]  = '{"done_smp",    1, 0, 1, 0, 0, 0, 0, 1, 0};
        vecs[6]  = '{"ok68",        1, 0, 1, 0, 0, 1, 0, 0, 0};
        vecs[7]  = '{"ok_hold",     5, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[8]  = '{"reinit_smp",  1, 0, 0, 1, 0, 1, 0, 0, 0};
        vecs[9]  = '{"reinit_busy", 1, 0, 0, 0, 0, 0, 0, 1, 0};
        vecs[10] = '{"reinit_pwr",  1, 0, 0, 1, 0, 0, 0, 1, 0};
        vecs[11] = '{"pwr_dly2",   58, 0, 0, 0, 0, 0, 0, 1, 0};
        vecs[12] = '{"start_r",     1, 0, 0, 0, 1, 0, 0, 1, 0};
        vecs[13] = '{"start_r_end", 1, 0, 0, 0, 0, 0, 0, 1, 0};
        vecs[14] = '{"pre_expiry", 98, 0, 0, 0, 0, 0, 0, 1, 0};
        vecs[15] = '{"expiry_done", 1, 0, 1, 0, 0, 0, 0, 1, 0};
        vecs[16] = '{"expiry_ok",   1, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[17] = '{"no_retry",   70, 0, 0, 0, 0, 1, 0, 0, 0};

        foreach (vecs[i]) begin
            rst_i        = vecs[i].rst;
            init_done_i  = vecs[i].done;
            reinit_req_i = vecs[i].reinit;
            step(int'(vecs[i].cycles));
            chk_outs(vecs[i].name, vecs[i].start, vecs[i].ok, vecs[i].fail, vecs[i].busy,
                     vecs[i].retry);
        end

        // Timeouts with init_done tied low: three pulses 161 apart, then FAIL.
        init_done_i  = 1'b0;
        reinit_req_i = 1'b1;
        step(1);
        reinit_req_i = 1'b0;
        for (int t = 1; t <= 600; t++) begin
            step(1);
            if (init_start_o) pulses.push_back(t);
            if (t == 170) chk("retry_after_1st_to", 32'(retry_cnt_o), 32'd1);
        end
        chk("to_pulse_count", 32'(pulses.size()), 32'd3);
        chk("to_first_pulse", 32'(pulses.size() > 0 ? pulses[0] : 0), 32'd61);
        chk("to_gap1", 32'(pulses.size() > 1 ? pulses[1] - pulses[0] : 0), 32'd161);
        chk("to_gap2", 32'(pulses.size() > 2 ? pulses[2] - pulses[1] : 0), 32'd161);
        chk_outs("fail_state", 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
        step(50);
        chk_outs("fail_hold", 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);

        // Re-init from FAIL clears retry_cnt with the state change.
        reinit_req_i = 1'b1;
        step(1);
        reinit_req_i = 1'b0;
        chk("fail_reinit_retry", 32'(retry_cnt_o), 32'd0);
        step(1);
        chk_outs("fail_reinit_busy", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);

        // init_done held high through reset and delay: only honoured in WAIT_DONE.
        rst_i       = 1'b1;
        init_done_i = 1'b1;
        step(2);
        rst_i       = 1'b0;
        first_start = 0;
        first_ok    = 0;
        n_start     = 0;
        for (int t = 1; t <= 80; t++) begin
            step(1);
            if (init_start_o) begin
                n_start++;
                if (first_start == 0) first_start = t;
            end
            if (init_ok_o && first_ok == 0) first_ok = t;
        end
        chk("held_first_start", 32'(first_start), 32'd62);
        chk("held_start_count", 32'(n_start), 32'd1);
        chk("held_first_ok", 32'(first_ok), 32'd64);
        chk_outs("held_end", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);

        // Reset mid-WAIT_DONE after one retry: outputs return to reset values, full restart.
        rst_i       = 1'b1;
        init_done_i = 1'b0;
        step(2);
        rst_i = 1'b0;
        step(230);
        chk_outs("mid_wait_pre", 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
        rst_i = 1'b1;
        step(1);
        chk_outs("mid_wait_rst", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        rst_i       = 1'b0;
        first_start = 0;
        for (int t = 1; t <= 80; t++) begin
            step(1);
            if (init_start_o && first_start == 0) first_start = t;
        end
        chk("restart_first_start", 32'(first_start), 32'd62);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
